// File: rtl/vec_seq_ctrl.sv
// Element sequencer for the CFU vector datapath: command latch, per-element strobe, drain, response.
// Optional define VEC_SEQ_STALL_EN adds a dp_stall input that freezes element issue in EXEC.
module vec_seq_ctrl #(
    parameter int unsigned VLMAX   = 8,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [9:0]       cmd_payload_function_id,
    input  logic [31:0]      cmd_payload_inputs_0,
    input  logic [31:0]      cmd_payload_inputs_1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_payload_outputs_0,
    output logic             dec_valid,
    output logic [9:0]       dec_function_id,
    output logic [31:0]      dec_inputs_0,
    output logic [31:0]      dec_inputs_1,
    output logic             elem_en,
    output logic [CNT_W-1:0] elem_idx,
    input  logic [31:0]      dp_byte_sum,
`ifdef VEC_SEQ_STALL_EN
    input  logic             dp_stall,
`endif
    output logic [CNT_W-1:0] vl,
    output logic             busy,
    output logic             err
);

    localparam int unsigned PW = (ALU_LAT > 0) ? ALU_LAT : 1;

    typedef enum logic [1:0] {StIdle, StExec, StDrain, StResp} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] vl_q, vl_d;
    logic [1:0]       drain_q, drain_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      rsp_q, rsp_d;
    logic [PW-1:0]    en_pipe_q;
    logic             err_q, err_d;
    logic             dec_valid_q, dec_valid_d;
    logic [9:0]       dec_fid_q;
    logic [31:0]      dec_in0_q, dec_in1_q;
    logic             stall, accept, last_elem, en_del;
    logic [2:0]       op_in, op_q;

`ifdef VEC_SEQ_STALL_EN
    assign stall = dp_stall;
`else
    assign stall = 1'b0;
`endif

    assign op_in     = cmd_payload_function_id[2:0];
    assign op_q      = dec_fid_q[2:0];
    assign accept    = cmd_valid && (state_q == StIdle);
    assign elem_en   = (state_q == StExec) && !stall;
    assign last_elem = (idx_q == vl_q - CNT_W'(1));
    // elem_en aligned to the cycle its dp_byte_sum is valid
    assign en_del    = (ALU_LAT == 0) ? elem_en : en_pipe_q[PW-1];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vl_d        = vl_q;
        drain_d     = drain_q;
        rsp_d       = rsp_q;
        err_d       = err_q;
        dec_valid_d = dec_valid_q;
        acc_d       = acc_q;
        if (en_del && op_q == 3'd5) begin
            acc_d = acc_q + dp_byte_sum;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    dec_valid_d = 1'b1;
                    case (op_in)
                        3'd0: begin
                            vl_d    = (cmd_payload_inputs_0 > 32'(VLMAX)) ? CNT_W'(VLMAX)
                                                                          : cmd_payload_inputs_0[CNT_W-1:0];
                            rsp_d   = 32'(vl_d);
                            state_d = StResp;
                        end
                        3'd6, 3'd7: begin
                            err_d   = 1'b1;
                            rsp_d   = 32'hFFFF_FFFF;
                            state_d = StResp;
                        end
                        default: begin
                            if (vl_q == '0) begin
                                rsp_d   = 32'd0;
                                state_d = StResp;
                            end else begin
                                idx_d   = '0;
                                acc_d   = 32'd0;
                                state_d = StExec;
                            end
                        end
                    endcase
                end
            end
            StExec: begin
                if (!stall) begin
                    idx_d = idx_q + CNT_W'(1);
                    if (last_elem) begin
                        if (ALU_LAT > 0) begin
                            drain_d = 2'd0;
                            state_d = StDrain;
                        end else begin
                            rsp_d   = (op_q == 3'd5) ? acc_d : 32'd0;
                            state_d = StResp;
                        end
                    end
                end
            end
            StDrain: begin
                if (drain_q == 2'(ALU_LAT - 1)) begin
                    rsp_d   = (op_q == 3'd5) ? acc_d : 32'd0;
                    state_d = StResp;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    dec_valid_d = 1'b0;
                    rsp_d       = 32'd0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            vl_q        <= '0;
            drain_q     <= 2'd0;
            acc_q       <= 32'd0;
            rsp_q       <= 32'd0;
            err_q       <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_fid_q   <= 10'd0;
            dec_in0_q   <= 32'd0;
            dec_in1_q   <= 32'd0;
            en_pipe_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vl_q        <= vl_d;
            drain_q     <= drain_d;
            acc_q       <= acc_d;
            rsp_q       <= rsp_d;
            err_q       <= err_d;
            dec_valid_q <= dec_valid_d;
            if (accept) begin
                dec_fid_q <= cmd_payload_function_id;
                dec_in0_q <= cmd_payload_inputs_0;
                dec_in1_q <= cmd_payload_inputs_1;
            end
            en_pipe_q[0] <= elem_en;
            for (int unsigned i = 1; i < PW; i++) begin
                en_pipe_q[i] <= en_pipe_q[i-1];
            end
        end
    end

    assign cmd_ready             = (state_q == StIdle);
    assign rsp_valid             = (state_q == StResp);
    assign busy                  = (state_q != StIdle);
    assign rsp_payload_outputs_0 = rsp_q;
    assign dec_valid             = dec_valid_q;
    assign dec_function_id       = dec_fid_q;
    assign dec_inputs_0          = dec_in0_q;
    assign dec_inputs_1          = dec_in1_q;
    assign elem_idx              = idx_q;
    assign vl                    = vl_q;
    assign err                   = err_q;

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// Scoreboard bench for vec_seq_ctrl: directed scenarios then random commands against a
// command-level model (vl clamp, element count, byte-sum total, sticky error).
module tb_vec_seq_ctrl;

    localparam int unsigned VLMAX = 8;
    localparam int unsigned CNT_W = 4;
    localparam int          LAT   = 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [9:0]       cmd_payload_function_id = '0;
    logic [31:0]      cmd_payload_inputs_0 = '0;
    logic [31:0]      cmd_payload_inputs_1 = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_payload_outputs_0;
    logic             dec_valid;
    logic [9:0]       dec_function_id;
    logic [31:0]      dec_inputs_0;
    logic [31:0]      dec_inputs_1;
    logic             elem_en;
    logic [CNT_W-1:0] elem_idx;
    logic [31:0]      dp_byte_sum = '0;
    logic [CNT_W-1:0] vl;
    logic             busy;
    logic             err;

    vec_seq_ctrl #(.VLMAX(VLMAX), .CNT_W(CNT_W), .ALU_LAT(LAT)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .dec_valid               (dec_valid),
        .dec_function_id         (dec_function_id),
        .dec_inputs_0            (dec_inputs_0),
        .dec_inputs_1            (dec_inputs_1),
        .elem_en                 (elem_en),
        .elem_idx                (elem_idx),
        .dp_byte_sum             (dp_byte_sum),
        .vl                      (vl),
        .busy                    (busy),
        .err                     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      data;
        logic [CNT_W-1:0] vl;
        logic             err;
        int               n_elem;
        int               lat;
        int               acc_cyc;
        logic [9:0]       fid;
        logic [31:0]      in0;
        logic [31:0]      in1;
    } exp_t;

    exp_t             sb[$];
    exp_t             cur;
    logic [31:0]      stage_q[$];
    logic [31:0]      dq[$];
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    int               elem_cnt = 0;
    int               last_acc = 0;
    int               mode = 0;
    logic             pend = 1'b0;
    logic             in_rsp = 1'b0;
    logic [31:0]      prev_data = '0;
    logic [CNT_W-1:0] vl_m = '0;
    logic             err_m = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (mode)
            1:       rsp_ready = 1'b0;
            2:       rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Datapath stand-in: answers each strobe one cycle later, junk otherwise
    always @(negedge clk) begin
        if (reset_n && elem_en) begin
            chk("elem_idx", 32'(elem_idx), 32'(elem_cnt));
            elem_cnt++;
            pend = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (pend && dq.size() > 0) dp_byte_sum = dq.pop_front();
        else dp_byte_sum = $urandom;
        pend = 1'b0;
    end

    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            if (!in_rsp) begin
                in_rsp    = 1'b1;
                prev_data = rsp_payload_outputs_0;
                if (sb.size() == 0) fail("unexpected_rsp");
                else chk("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
            end else begin
                chk("rsp_stable", rsp_payload_outputs_0, prev_data);
            end
            chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
            if (rsp_ready) begin
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                    chk("rsp_data", rsp_payload_outputs_0, cur.data);
                    chk("vl", 32'(vl), 32'(cur.vl));
                    chk("err", {31'b0, err}, {31'b0, cur.err});
                    chk("elem_count", 32'(elem_cnt), 32'(cur.n_elem));
                    chk("dec_fid", 32'(dec_function_id), 32'(cur.fid));
                    chk("dec_in0", dec_inputs_0, cur.in0);
                    chk("dec_in1", dec_inputs_1, cur.in1);
                    chk("dec_valid", {31'b0, dec_valid}, 32'd1);
                end
                in_rsp   = 1'b0;
                elem_cnt = 0;
                dq.delete();
            end
        end
    end

    task automatic do_cmd(input logic [2:0] op, input logic [31:0] in0, input logic [31:0] in1);
        exp_t        e;
        bit          ok;
        logic [31:0] s;
        ok = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid               = 1'b1;
        cmd_payload_function_id = {2'b00, 5'($urandom_range(0, 31)), op};
        cmd_payload_inputs_0    = in0;
        cmd_payload_inputs_1    = in1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail("cmd_accept_timeout");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.fid                   = cmd_payload_function_id;
        e.in0                   = in0;
        e.in1                   = in1;
        cmd_valid               = 1'b0;
        cmd_payload_function_id = 10'($urandom);
        cmd_payload_inputs_0    = $urandom;
        cmd_payload_inputs_1    = $urandom;
        e.n_elem                = 0;
        if (op == 3'd0) begin
            e.data = (in0 > VLMAX) ? 32'(VLMAX) : in0;
            vl_m   = e.data[CNT_W-1:0];
        end else if (op >= 3'd6) begin
            err_m  = 1'b1;
            e.data = 32'hFFFF_FFFF;
        end else begin
            e.n_elem = int'(vl_m);
            e.data   = 32'd0;
            if (op == 3'd5 && e.n_elem > 0) begin
                dq.delete();
                while (stage_q.size() < e.n_elem) stage_q.push_back($urandom);
                s = 32'd0;
                for (int i = 0; i < e.n_elem; i++) begin
                    dq.push_back(stage_q[i]);
                    s = s + stage_q[i];
                end
                e.data = s;
            end
        end
        stage_q.delete();
        e.vl      = vl_m;
        e.err     = err_m;
        e.lat     = (e.n_elem > 0) ? e.n_elem + LAT : 0;
        e.acc_cyc = cyc;
        last_acc  = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("idle_timeout");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_elem_en"}, {31'b0, elem_en}, 32'd0);
        chk({tag, "_elem_idx"}, 32'(elem_idx), 32'd0);
        chk({tag, "_vl"}, 32'(vl), 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        chk({tag, "_dec_valid"}, {31'b0, dec_valid}, 32'd0);
        chk({tag, "_rsp_data"}, rsp_payload_outputs_0, 32'd0);
        chk({tag, "_dec_fid"}, 32'(dec_function_id), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n_rel;
        logic [2:0] op;
        logic [31:0] a;
        int r;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        do_cmd(3'd2, 32'd7, 32'd9);
        do_cmd(3'd7, 32'd1, 32'd2);
        do_cmd(3'd1, 32'd3, 32'd4);
        do_cmd(3'd0, 32'd5, 32'd0);
        do_cmd(3'd0, 32'h0000_0100, 32'd0);
        do_cmd(3'd0, 32'd4, 32'd0);
        stage_q.push_back(32'd10);
        stage_q.push_back(32'd20);
        stage_q.push_back(32'd30);
        stage_q.push_back(32'd40);
        do_cmd(3'd5, 32'hA5A5_0001, 32'h5A5A_0002);

        // Response back-pressure and a command queued behind it
        do_cmd(3'd0, 32'd3, 32'd0);
        wait_idle();
        @(negedge clk);
        mode = 1;
        do_cmd(3'd4, $urandom, $urandom);
        fork
            do_cmd(3'd0, 32'd8, 32'd0);
        join_none
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("hold_rsp_timeout");
        repeat (4) @(negedge clk);
        n_rel = cyc;
        mode  = 2;
        repeat (6) @(negedge clk);
        chk("accept_after_release", 32'(last_acc), 32'(n_rel + 3));
        mode = 0;

        // Reset in the middle of an 8-element command
        wait_idle();
        do_cmd(3'd1, $urandom, $urandom);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (elem_en && elem_idx == CNT_W'(3)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("idx3_timeout");
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        sb.delete();
        dq.delete();
        elem_cnt = 0;
        in_rsp   = 1'b0;
        vl_m     = '0;
        err_m    = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("held_reset");
        reset_n = 1'b1;

        do_cmd(3'd0, 32'd2, 32'd0);
        do_cmd(3'd3, $urandom, $urandom);
        wait_idle();

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 15);
            if (r < 4) op = 3'd0;
            else if (r < 14) op = 3'(1 + (r % 5));
            else op = 3'(6 + (r % 2));
            case ($urandom_range(0, 2))
                0:       a = 32'($urandom_range(0, 12));
                1:       a = 32'h0000_0100;
                default: a = $urandom;
            endcase
            do_cmd(op, a, $urandom);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_seq_ctrl.md
Name: vec_seq_ctrl

Overview:
Sequencer for the CFU vector datapath (decoder, vector register file, ALU, byte accumulator). It accepts one CFU command per handshake and holds the decoded command stable. It then steps an element index from 0 to vl-1, strobing the datapath once per element, drains the ALU pipeline, and returns one response. It also owns the vector-length register written by vsetvli.

Parameters:
VLMAX, 8, maximum vector length in elements
CNT_W, 4, element counter / vl register width; must satisfy 2^CNT_W > VLMAX
ALU_LAT, 1, datapath pipeline depth in cycles from elem_en to result valid (0..3)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  CFU command valid
cmd_ready  out  1  CFU command ready
cmd_payload_function_id  in  10  [2:0]=op, [7:3]=vector reg index
cmd_payload_inputs_0  in  32  operand 0
cmd_payload_inputs_1  in  32  operand 1
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_payload_outputs_0  out  32  response data
dec_valid  out  1  held command valid to decoder (its cmd_valid input)
dec_function_id  out  10  latched function_id
dec_inputs_0  out  32  latched inputs_0
dec_inputs_1  out  32  latched inputs_1
elem_en  out  1  per-element datapath strobe
elem_idx  out  CNT_W  current element index
dp_byte_sum  in  32  datapath vbacc partial sum; valid ALU_LAT cycles after elem_en
vl  out  CNT_W  current vector length
busy  out  1  high in any state other than IDLE
err  out  1  sticky illegal-op flag

Behaviour:
- Reset (async, reset_n=0): state=IDLE. cmd_ready=1, all other outputs 0, including vl=0, the latches, acc and err.
- States: IDLE, EXEC, DRAIN, RESP.
- IDLE: cmd_ready=1. On cmd_valid && cmd_ready, latch function_id and inputs into the dec_* registers, with dec_valid=1 from the next cycle. Next state depends on op:
  - op 0 (vsetvli): vl <= (inputs_0 > VLMAX) ? VLMAX : inputs_0[CNT_W-1:0], using an unsigned 32-bit compare. Go to RESP with data equal to the new vl, zero-extended. No elem_en is issued.
  - ops 1-5 with vl==0: go to RESP with data 0. No elem_en is issued.
  - ops 1-5 with vl!=0: idx=0, acc=0, go to EXEC.
  - ops 6-7: set err=1, go to RESP with data 32'hFFFF_FFFF.
- EXEC: elem_en=1 and elem_idx=idx on every cycle in this state. idx increments by 1 per cycle. After the cycle with idx==vl-1, go to DRAIN if ALU_LAT>0, else go to RESP. A command of vl elements occupies exactly vl EXEC cycles.
- DRAIN: elem_en=0. Lasts ALU_LAT cycles, counted by a drain counter, then goes to RESP.
- Accumulate: for op 5 only, acc += dp_byte_sum on each cycle where the elem_en delayed by ALU_LAT is high. Addition wraps modulo 2^32.
- RESP: rsp_valid=1 and rsp_payload_outputs_0 is held stable.
  - Data: new vl for op 0, acc for op 5, 0 for ops 1-4, 32'hFFFF_FFFF for ops 6-7.
  - When rsp_ready=1, go to IDLE next cycle, clear dec_valid, and keep vl.
  - Data must not change while rsp_valid=1 && rsp_ready=0.
- cmd_ready=0 in EXEC, DRAIN and RESP. A cmd_valid arriving then is ignored and waits for the next IDLE.
- Minimum command-to-command period is 2 cycles (IDLE then RESP), reached with rsp_ready held at 1.
- dec_* values stay constant from the latch until the return to IDLE.
- err is sticky and cleared only by reset.
- A vsetvli while vl is nonzero simply overwrites vl.
- Reset asserted mid-EXEC: the index is abandoned, no response is produced, vl returns to 0.

Optional Feature:
VEC_SEQ_STALL_EN:
- Defined: adds an input port dp_stall (1 bit). While dp_stall=1 in EXEC: elem_en=0, idx holds, the drain counter holds, and the accumulate pipeline advances with a bubble. The EXEC cycle count becomes vl plus the number of stalled cycles.
- Undefined: the port does not exist and EXEC never stalls.

Test Plan:
- Reset, then vsetvli with inputs_0=5 -> one cycle after accept, rsp_valid=1 and data=5. vl=5, with no elem_en pulse.
- vsetvli with inputs_0=32'h0000_0100 (VLMAX=8) -> vl=8 and data=8. The unsigned compare must not truncate (256[3:0]=0 would be wrong).
- vl=4, op 5 (vbacc), dp_byte_sum=10,20,30,40 arriving ALU_LAT=1 cycles after each elem_en -> elem_idx runs 0,1,2,3 in 4 consecutive cycles, 1 DRAIN cycle follows, then data=100.
- vl=3, op 4 (vmul), rsp_ready held 0 for 5 cycles -> rsp_valid and data=0 stay stable and cmd_ready=0 throughout. A second cmd_valid is not accepted until 1 cycle after rsp_ready=1.
- After reset (vl=0), op 2 -> immediate response data=0 with no elem_en. Then op 7 -> data=32'hFFFF_FFFF and err=1; err stays 1 across a following legal command.
- vl=8, op 1, reset_n pulsed low at idx=3 -> all outputs reset asynchronously with no rsp_valid. Then vsetvli 2 followed by op 3 -> exactly 2 elem_en pulses.
